mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 16, meaning address width.
REQ-002 The block SHALL have parameter DW, default 16, meaning data width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning the number of implemented memory words.
REQ-004 The block SHALL have these ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req0, req1  input  1 each  access request, requester 0 and requester 1.
- we0, we1  input  1 each  1 = write, 0 = read; valid while reqN=1.
- addr0, addr1  input  AW each  word address; valid while reqN=1.
- wdata0, wdata1  input  DW each  write data; valid while reqN=1.
- ack0, ack1  output  1 each  one-cycle completion pulse.
- err0, err1  output  1 each  out-of-range flag; valid with ackN.
- rdata0, rdata1  output  DW each  read result; valid with ackN.
- busy  output  1  high whenever state is not IDLE.
- m_raddr  output  AW  memory read address.
- m_rdata  input  DW  memory combinational read data.
- m_wen  output  1  memory write enable.
- m_waddr  output  AW  memory write address.
- m_wdata  output  DW  memory write data.

Function
REQ-005 The block SHALL implement the FSM states IDLE, ACCESS and DONE, with transitions IDLE->ACCESS when (req0|req1)=1, ACCESS->DONE unconditionally, and DONE->IDLE unconditionally.
REQ-006 In IDLE with any request, the block SHALL latch the winner index, we, addr and wdata into internal registers on the clock edge.
REQ-007 Arbitration SHALL be round-robin:
- A single requester wins.
- When both request, the one not named by the last_grant register wins.
- last_grant SHALL update to the winner on the IDLE->ACCESS edge.
REQ-008 In ACCESS, m_raddr and m_waddr SHALL equal the latched address and m_wdata SHALL equal the latched wdata.
REQ-009 In ACCESS, m_wen SHALL be 1 only if the latched we=1 and the latched addr < DEPTH; m_wen SHALL be 0 in every other state.
REQ-010 On the ACCESS->DONE edge, the block SHALL capture m_rdata into the winner's rdataN register for an in-range read, and capture 0 for a write or an out-of-range access.
REQ-011 In DONE, the block SHALL hold ackN=1 for the winner only, for exactly one cycle, with errN=1 iff the latched addr >= DEPTH.
REQ-012 Latency from req sampled in IDLE to ack SHALL be 2 cycles, giving a throughput of one access per 3 cycles.
REQ-013 rdataN SHALL hold its value until the next completed access by the same requester; the loser's rdata SHALL be unchanged.
REQ-014 Requests SHALL be sampled only in IDLE; req changes during ACCESS or DONE SHALL be ignored.
REQ-015 A requester still asserting req in the cycle after its ack SHALL be treated as a new request.
REQ-016 An out-of-range write SHALL NOT assert m_wen.
REQ-017 Address comparison SHALL be unsigned across the full AW bits.
REQ-018 busy SHALL be 1 in ACCESS and DONE, and 0 in IDLE.
REQ-019 Outside ACCESS, m_raddr, m_waddr and m_wdata SHALL be 0.

Reset
REQ-020 While rst_n=0, the block SHALL hold state=IDLE and last_grant=1, so that requester 0 wins the first contention.
REQ-021 While rst_n=0, all outputs SHALL be 0: ack0/1, err0/1, rdata0/1, busy, m_wen, m_raddr, m_waddr and m_wdata.
REQ-022 Reset asserted during ACCESS SHALL clear m_wen immediately and asynchronously, with no ack issued for the aborted access.
REQ-023 After rst_n deasserts, the block SHALL take the first request sampled on the first following posedge.

Verification
REQ-024 Single write: req0=1, we0=1, addr0=0x0010, wdata0=0xBEEF -> m_wen=1 for exactly one cycle with m_waddr=0x0010; ack0 two cycles after sampling; err0=0; rdata0=0.
REQ-025 Read-back: memory word 0x0010 = 0xBEEF; req1=1, we1=0, addr1=0x0010 -> ack1 after 2 cycles with rdata1=0xBEEF; rdata0 unchanged.
REQ-026 Contention: req0 and req1 both held continuously from reset -> grants alternate 0,1,0,1 with acks spaced 3 cycles apart and no double acks.
REQ-027 Out-of-range: req0=1, we0=1, addr0=0x0100 with DEPTH=256 -> m_wen stays 0; ack0=1 with err0=1; rdata0=0.
REQ-028 Reset mid-access: rst_n=0 asserted during ACCESS of a write -> m_wen falls immediately, no ack occurs, and after release a pending req1 with req0 also asserted is granted to requester 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester, round-robin arbiter in front of a single-port-style memory.
// Each access walks IDLE -> ACCESS -> DONE; the memory is driven only during
// ACCESS and the winner gets a one-cycle ack (with err/rdata) in DONE.
module mem_arbiter #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] m_raddr,
  input  logic [DW-1:0] m_rdata,
  output logic          m_wen,
  output logic [AW-1:0] m_waddr,
  output logic [DW-1:0] m_wdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  // One extra bit so the bound compare is unsigned over the full address width.
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < LP_DEPTH);
  endfunction

  state_t        r_state;
  logic          r_last_grant;
  logic          r_win;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic          r_ack0, r_ack1, r_err0, r_err1, r_busy, r_m_wen;
  logic [DW-1:0] r_rdata0, r_rdata1, r_m_wdata;
  logic [AW-1:0] r_m_raddr, r_m_waddr;

  logic          w_any;
  logic          w_winner;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic [DW-1:0] w_cap_data;

  // Round-robin pick of the winner and the request fields it brings along.
  always_comb begin
    w_any       = req0 | req1;
    w_winner    = 1'b0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (req0 && req1) begin
      w_winner = ~r_last_grant;
    end else if (req1) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
    if (w_winner) begin
      w_sel_we    = we1;
      w_sel_addr  = addr1;
      w_sel_wdata = wdata1;
    end else begin
      w_sel_we    = we0;
      w_sel_addr  = addr0;
      w_sel_wdata = wdata0;
    end
  end

  // Value handed back to the winner: memory data for in-range reads, else zero.
  always_comb begin
    w_cap_data = '0;
    if (!r_we && in_range(r_addr)) begin
      w_cap_data = m_rdata;
    end else begin
      w_cap_data = '0;
    end
  end

  // Access FSM with all outputs registered; reset clears the memory strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_win        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_busy       <= 1'b0;
      r_m_wen      <= 1'b0;
      r_m_raddr    <= '0;
      r_m_waddr    <= '0;
      r_m_wdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state      <= ACCESS;
            r_win        <= w_winner;
            r_last_grant <= w_winner;
            r_we         <= w_sel_we;
            r_addr       <= w_sel_addr;
            r_m_raddr    <= w_sel_addr;
            r_m_waddr    <= w_sel_addr;
            r_m_wdata    <= w_sel_wdata;
            r_m_wen      <= w_sel_we & in_range(w_sel_addr);
            r_busy       <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        ACCESS: begin
          r_state   <= DONE;
          r_m_wen   <= 1'b0;
          r_m_raddr <= '0;
          r_m_waddr <= '0;
          r_m_wdata <= '0;
          if (r_win) begin
            r_rdata1 <= w_cap_data;
          end else begin
            r_rdata0 <= w_cap_data;
          end
          r_ack1 <= r_win;
          r_ack0 <= ~r_win;
          r_err1 <= r_win & ~in_range(r_addr);
          r_err0 <= ~r_win & ~in_range(r_addr);
        end
        DONE: begin
          r_state <= IDLE;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_ack0    <= 1'b0;
          r_ack1    <= 1'b0;
          r_err0    <= 1'b0;
          r_err1    <= 1'b0;
          r_busy    <= 1'b0;
          r_m_wen   <= 1'b0;
          r_m_raddr <= '0;
          r_m_waddr <= '0;
          r_m_wdata <= '0;
        end
      endcase
    end
  end

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign err0    = r_err0;
  assign err1    = r_err1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;
  assign busy    = r_busy;
  assign m_wen   = r_m_wen;
  assign m_raddr = r_m_raddr;
  assign m_waddr = r_m_waddr;
  assign m_wdata = r_m_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus hand sequences for contention,
// back-to-back requests and reset during an access. Acks are scored against
// a queue of expectations pushed when each request is driven.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1, busy, m_wen;
  logic [15:0] rdata0, rdata1, m_raddr, m_rdata, m_waddr, m_wdata;

  mem_arbiter #(.AW(16), .DW(16), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .m_raddr(m_raddr), .m_rdata(m_rdata), .m_wen(m_wen),
    .m_waddr(m_waddr), .m_wdata(m_wdata)
  );

  always #5 clk = ~clk;

  // Memory model: 256 words, combinational read, written on posedge when m_wen.
  logic [15:0] mem [0:255];
  logic        mem_clr_n = 1'b0;
  assign m_rdata = (m_raddr < 16'd256) ? mem[m_raddr[7:0]] : 16'd0;

  // Clear the model once at start, then accept DUT writes.
  always @(posedge clk) begin
    if (!mem_clr_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'd0;
    end else if (m_wen) begin
      mem[m_waddr[7:0]] <= m_wdata;
    end
  end

  int cyc = 0;
  // Posedge counter used to time acks.
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic        win;
    logic        err;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (ack0 || ack1)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {62'd0, ack1, ack0}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("ack_who", {62'd0, ack1, ack0}, e.win ? 64'd2 : 64'd1);
        check("ack_cycle", 64'(cyc), 64'(e.cyc));
        check("ack_err", {63'd0, e.win ? err1 : err0}, {63'd0, e.err});
        check("ack_rdata", {48'd0, e.win ? rdata1 : rdata0}, {48'd0, e.rdata});
      end
    end
  end

  typedef struct {
    logic        r0, w0;
    logic [15:0] a0, d0;
    logic        r1, w1;
    logic [15:0] a1, d1;
    logic        ew, eerr, ewen;
    logic [15:0] erd;
  } vec_t;
  vec_t vt [10];
  logic [15:0] exp_rd [2];

  initial begin
    // r0 w0 a0 d0 | r1 w1 a1 d1 | winner err wen rdata
    vt[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
    vt[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hBEEF};
    vt[2] = '{1'b1, 1'b1, 16'h0100, 16'hDEAD, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hCAFE, 1'b1, 1'b0, 1'b1, 16'h0000};
    vt[4] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hCAFE};
    vt[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h00FF, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h0000};
    vt[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1234};
    vt[7] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[8] = '{1'b1, 1'b1, 16'h0001, 16'h5A5A, 1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1234};
    vt[9] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 16'h0000; wdata1 = 16'h0000;
    repeat (3) @(negedge clk);
    mem_clr_n = 1'b1;

    // Everything quiet while in reset.
    check("rst_ack0", {63'd0, ack0}, 64'd0);
    check("rst_ack1", {63'd0, ack1}, 64'd0);
    check("rst_err0", {63'd0, err0}, 64'd0);
    check("rst_err1", {63'd0, err1}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_m_wen", {63'd0, m_wen}, 64'd0);
    check("rst_rdata", {32'd0, rdata1, rdata0}, 64'd0);
    check("rst_m_bus", {16'd0, m_raddr, m_waddr, m_wdata}, 64'd0);
    rst_n = 1'b1;

    // Table: one access per 3 cycles, driven in IDLE right after release.
    for (int i = 0; i < 10; i++) begin
      req0 = vt[i].r0; we0 = vt[i].w0; addr0 = vt[i].a0; wdata0 = vt[i].d0;
      req1 = vt[i].r1; we1 = vt[i].w1; addr1 = vt[i].a1; wdata1 = vt[i].d1;
      sb_q.push_back('{vt[i].ew, vt[i].eerr, vt[i].erd, cyc + 2});
      @(negedge clk);  // ACCESS
      check("acc_busy", {63'd0, busy}, 64'd1);
      check("acc_m_wen", {63'd0, m_wen}, {63'd0, vt[i].ewen});
      check("acc_m_waddr", {48'd0, m_waddr}, {48'd0, vt[i].ew ? vt[i].a1 : vt[i].a0});
      check("acc_m_raddr", {48'd0, m_raddr}, {48'd0, vt[i].ew ? vt[i].a1 : vt[i].a0});
      check("acc_m_wdata", {48'd0, m_wdata}, {48'd0, vt[i].ew ? vt[i].d1 : vt[i].d0});
      // Inputs move during the access; they must not matter.
      req0 = 1'b0; req1 = 1'b0;
      addr0 = 16'($urandom); addr1 = 16'($urandom);
      @(negedge clk);  // DONE
      check("done_m_wen", {63'd0, m_wen}, 64'd0);
      check("done_m_bus", {16'd0, m_raddr, m_waddr, m_wdata}, 64'd0);
      @(negedge clk);  // IDLE
      exp_rd[vt[i].ew] = vt[i].erd;
      check("idle_busy", {63'd0, busy}, 64'd0);
      check("hold_rdata", {32'd0, rdata1, rdata0}, {32'd0, exp_rd[1], exp_rd[0]});
    end

    // Requester keeps req high after its ack: served again 3 cycles later.
    begin
      int n0;
      n0 = cyc;
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      sb_q.push_back('{1'b0, 1'b0, 16'hBEEF, n0 + 2});
      sb_q.push_back('{1'b0, 1'b0, 16'hBEEF, n0 + 5});
      repeat (4) @(negedge clk);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
    end

    // Both requesters held from reset: 0,1,0,1 with acks 3 cycles apart.
    begin
      int n0;
      rst_n = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h00FF;
      @(negedge clk);
      check("rst2_rdata", {32'd0, rdata1, rdata0}, 64'd0);
      rst_n = 1'b1;
      n0 = cyc;
      for (int k = 0; k < 4; k++)
        sb_q.push_back('{1'(k % 2), 1'b0, (k % 2) ? 16'h1234 : 16'hBEEF, n0 + 2 + 3 * k});
      repeat (11) @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);
    end

    // Reset in the middle of a write: strobe drops at once, no ack, no write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h7777;
    req1 = 1'b0;
    @(posedge clk);
    #2;
    check("abort_wen_before", {63'd0, m_wen}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_wen_after", {63'd0, m_wen}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_m_waddr", {48'd0, m_waddr}, 64'd0);
    we0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
    @(negedge clk);
    rst_n = 1'b1;
    // Requester 0 wins after reset; reading 0x0030 proves the write never landed.
    sb_q.push_back('{1'b0, 1'b0, 16'h0000, cyc + 2});
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
